// File: rtl/mcrc.sv
// Byte-wide MODBUS RTU CRC-16 accumulator (reflected POLY, INIT preset, no final XOR).
// Optional MCRC_RESIDUE_EN adds registered crc_ok, set when the updated CRC is zero.
module mcrc #(
  parameter logic [15:0] INIT = 16'hFFFF,
  parameter logic [15:0] POLY = 16'hA001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [7:0]  din,
`ifdef MCRC_RESIDUE_EN
  output logic        crc_ok,
`endif
  output logic [15:0] crc
);

  logic [15:0] r_crc = INIT;
  logic [15:0] w_next;

  // Eight LSB-first shift/XOR steps unrolled into one combinational byte update.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] t;
    t = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      if (t[0]) t = (t >> 1) ^ POLY;
      else      t = t >> 1;
    end
    return t;
  endfunction

  always_comb begin
    w_next = crc_byte(r_crc, din);
  end

  always_ff @(posedge clk) begin
    if (reset)      r_crc <= INIT;
    else if (ready) r_crc <= w_next;
  end

  assign crc = r_crc;

`ifdef MCRC_RESIDUE_EN
  logic r_ok = 1'b0;

  always_ff @(posedge clk) begin
    if (reset)      r_ok <= 1'b0;
    else if (ready) r_ok <= (w_next == '0);
  end

  assign crc_ok = r_ok;
`endif

endmodule

// File: tb/tb_mcrc.sv
// Scoreboard bench for mcrc: stimulus queues expected CRC per cycle, a monitor checks at negedge.
module tb_mcrc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] crc;
`ifdef MCRC_RESIDUE_EN
  logic        crc_ok;
`endif

  mcrc #(.INIT(16'hFFFF), .POLY(16'hA001)) dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .din   (din),
`ifdef MCRC_RESIDUE_EN
    .crc_ok(crc_ok),
`endif
    .crc   (crc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [15:0] exp;
    logic        exp_ok;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_crc = 16'hFFFF;
  logic        m_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial reference: feedback is CRC LSB XOR incoming data bit.
  function automatic logic [15:0] mdl(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (crc !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d crc actual=%h required=%h", e.name, cyc, crc, e.exp);
      end
`ifdef MCRC_RESIDUE_EN
      checks++;
      if (crc_ok !== e.exp_ok) begin
        errors++;
        $display("FAIL %s_ok cyc=%0d crc_ok actual=%b required=%b", e.name, cyc, crc_ok, e.exp_ok);
      end
`endif
    end
  end

  // One clock of stimulus; queues the model value expected after the edge.
  task automatic step(input logic rst, input logic rdy, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst;
    ready = rdy;
    din   = d;
    if (rst) begin
      m_crc = 16'hFFFF;
      m_ok  = 1'b0;
    end else if (rdy) begin
      m_crc = mdl(m_crc, d);
      m_ok  = (m_crc == 16'h0000);
    end
    e.tgt = cyc + 1;
    e.exp = m_crc;
    e.exp_ok = m_ok;
    e.name = "track";
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Hand-computed constant check on the current CRC, queued for the next monitor pass.
  task automatic expect_hand(input logic [15:0] v, input string nm);
    exp_t e;
    e.tgt = cyc;
    e.exp = v;
    e.exp_ok = (v == 16'h0000);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  logic [7:0] f1[6]  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A};
  logic [7:0] f2[6]  = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
  logic [7:0] asc[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial begin
    step(1'b1, 1'b0, 8'h00);
    expect_hand(16'hFFFF, "reset");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'($urandom));
      expect_hand(16'hFFFF, "idle_hold");
    end

    foreach (f1[i]) step(1'b0, 1'b1, f1[i]);
    expect_hand(16'hCDC5, "frame1");
    step(1'b0, 1'b1, 8'hC5);
    step(1'b0, 1'b1, 8'hCD);
    expect_hand(16'h0000, "residue");
    idle(2);

    step(1'b1, 1'b0, 8'h00);
    foreach (f2[i]) step(1'b0, 1'b1, f2[i]);
    expect_hand(16'h0B98, "frame2_b2b");
    step(1'b1, 1'b0, 8'h00);
    foreach (f2[i]) begin
      step(1'b0, 1'b1, f2[i]);
      idle(3);
    end
    expect_hand(16'h0B98, "frame2_gaps");

    step(1'b1, 1'b0, 8'h00);
    foreach (asc[i]) step(1'b0, 1'b1, asc[i]);
    expect_hand(16'h4B37, "ascii_check");

    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h03);
    step(1'b1, 1'b1, 8'h55);
    expect_hand(16'hFFFF, "reset_beats_ready");
    foreach (f1[i]) step(1'b0, 1'b1, f1[i]);
    expect_hand(16'hCDC5, "after_midreset");

    // Held ready folds the same byte twice.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    idle(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
